// File: rtl/echo_buffer_if.sv
// Handshake bundle between the echo engine, the command dispatcher and the UART
// receiver/transmitter pair.
interface echo_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              activate;
    logic              done;
    logic              overflow;
    logic [LW-1:0]     level;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              tx_active;
    logic              tx_done;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;

    modport master (
        output activate, rx_ready, rx_data, tx_active, tx_done,
        input  done, overflow, level, tx_data, tx_start
    );

    modport slave (
        input  activate, rx_ready, rx_data, tx_active, tx_done,
        output done, overflow, level, tx_data, tx_start
    );
endinterface

// File: rtl/echo_buffer.sv
// UART echo engine: buffers received bytes in a circular FIFO and replays them
// to the transmitter, either streaming or after the terminator has arrived.
module echo_buffer #(
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = 16,
    parameter logic [DATA_W-1:0] TERMINATOR  = DATA_W'(8'h55),
    parameter int                PACKET_MODE = 0
) (
    input  logic       clk,
    input  logic       reset,
    echo_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic TX_IDLE = 1'b0;
    localparam logic TX_BUSY = 1'b1;

    logic [1:0]        state;
    logic              tx_state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              done_q;
    logic              overflow_q;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;

    logic pop_en;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic rx_take;
    logic push;
    logic drop;
    logic is_term;
    logic flush;

    // Pops are gated by activate so an abort never launches another byte.
    always_comb begin
        pop_en     = (state == S_DRAIN) || ((state == S_RUN) && (PACKET_MODE == 0));
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(DEPTH));
        pop        = bus.activate && pop_en && (tx_state == TX_IDLE)
                     && !fifo_empty && !bus.tx_active;
        rx_take    = (state == S_RUN) && bus.activate && bus.rx_ready;
        push       = rx_take && (!fifo_full || pop);
        drop       = rx_take && fifo_full && !pop;
        is_term    = (bus.rx_data == TERMINATOR);
        flush      = (state == S_IDLE)
                     || (((state == S_RUN) || (state == S_DRAIN)) && !bus.activate);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            tx_state   <= TX_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            if (pop) begin
                tx_data_q  <= mem[rd_ptr];
                tx_start_q <= 1'b1;
                rd_ptr     <= rd_ptr + AW'(1);
                tx_state   <= TX_BUSY;
            end else if ((tx_state == TX_BUSY) && bus.tx_done) begin
                tx_state <= TX_IDLE;
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);

            case (state)
                S_IDLE: begin
                    if (bus.activate) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!bus.activate) begin
                        state <= S_IDLE;
                    end else begin
                        if (drop) begin
                            overflow_q <= 1'b1;
                        end
                        // A dropped terminator still ends the receive phase.
                        if (bus.rx_ready && is_term) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!bus.activate) begin
                        state <= S_IDLE;
                    end else if (fifo_empty && (tx_state == TX_IDLE) && !bus.tx_active) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!bus.activate && !bus.rx_ready) begin
                        state      <= S_IDLE;
                        done_q     <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Entering or sitting in IDLE empties the FIFO and clears overflow.
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.level    = count;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_echo_buffer.sv
// Bench for echo_buffer: four parameterisations share one stimulus bus, a UART
// transmitter model answers the selected instance, and queues hold the expected echoes.
module tb_echo_buffer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       activate = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;

    int sel = 0;
    int tx_time = 10;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int last_rx_cyc = 0;

    logic [7:0] got_q[$];
    int         start_cyc_q[$];
    int         lvl_q[$];
    int         overlap = 0;
    int         max_level = 0;
    bit         uart_busy = 1'b0;
    int         uart_cnt = 0;

    logic       done;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] level;

    echo_buffer_if #(.DATA_W(8), .DEPTH(16)) bus0 ();
    echo_buffer_if #(.DATA_W(8), .DEPTH(16)) bus1 ();
    echo_buffer_if #(.DATA_W(8), .DEPTH(4))  bus2 ();
    echo_buffer_if #(.DATA_W(8), .DEPTH(4))  bus3 ();

    assign bus0.activate = activate; assign bus0.rx_ready = rx_ready; assign bus0.rx_data = rx_data;
    assign bus0.tx_active = tx_active; assign bus0.tx_done = tx_done;
    assign bus1.activate = activate; assign bus1.rx_ready = rx_ready; assign bus1.rx_data = rx_data;
    assign bus1.tx_active = tx_active; assign bus1.tx_done = tx_done;
    assign bus2.activate = activate; assign bus2.rx_ready = rx_ready; assign bus2.rx_data = rx_data;
    assign bus2.tx_active = tx_active; assign bus2.tx_done = tx_done;
    assign bus3.activate = activate; assign bus3.rx_ready = rx_ready; assign bus3.rx_data = rx_data;
    assign bus3.tx_active = tx_active; assign bus3.tx_done = tx_done;

    echo_buffer #(.DATA_W(8), .DEPTH(16), .TERMINATOR(8'h55), .PACKET_MODE(0)) dut_s16 (.clk(clk), .reset(reset), .bus(bus0));
    echo_buffer #(.DATA_W(8), .DEPTH(16), .TERMINATOR(8'h55), .PACKET_MODE(1)) dut_p16 (.clk(clk), .reset(reset), .bus(bus1));
    echo_buffer #(.DATA_W(8), .DEPTH(4),  .TERMINATOR(8'h55), .PACKET_MODE(1)) dut_p4  (.clk(clk), .reset(reset), .bus(bus2));
    echo_buffer #(.DATA_W(8), .DEPTH(4),  .TERMINATOR(8'h55), .PACKET_MODE(0)) dut_s4  (.clk(clk), .reset(reset), .bus(bus3));

    always_comb begin
        done = bus0.done; overflow = bus0.overflow; tx_start = bus0.tx_start;
        tx_data = bus0.tx_data; level = bus0.level;
        case (sel)
            1: begin done = bus1.done; overflow = bus1.overflow; tx_start = bus1.tx_start;
                     tx_data = bus1.tx_data; level = bus1.level; end
            2: begin done = bus2.done; overflow = bus2.overflow; tx_start = bus2.tx_start;
                     tx_data = bus2.tx_data; level = 5'(bus2.level); end
            3: begin done = bus3.done; overflow = bus3.overflow; tx_start = bus3.tx_start;
                     tx_data = bus3.tx_data; level = 5'(bus3.level); end
            default: ;
        endcase
    end

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transmitter model: busy from tx_start, tx_done pulse tx_time cycles later.
    initial forever begin
        bit was_busy;
        @(negedge clk);
        was_busy = uart_busy;
        tx_done = 1'b0;
        if (uart_busy) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                tx_done = 1'b1;
                tx_active = 1'b0;
                uart_busy = 1'b0;
            end
        end
        if (tx_start) begin
            if (was_busy) overlap++;
            got_q.push_back(tx_data);
            start_cyc_q.push_back(cyc);
            lvl_q.push_back(int'(level));
            uart_busy = 1'b1;
            tx_active = 1'b1;
            uart_cnt = tx_time;
        end
        if (int'(level) > max_level) max_level = int'(level);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic uart_reset();
        got_q.delete(); start_cyc_q.delete(); lvl_q.delete();
        overlap = 0; max_level = 0; uart_busy = 1'b0; uart_cnt = 0;
        tx_active = 1'b0; tx_done = 1'b0;
    endtask

    task automatic start_test(input int s, input int t);
        sel = s; tx_time = t; activate = 1'b0; rx_ready = 1'b0;
        reset = 1'b0;
        tick(2);
        uart_reset();
        reset = 1'b1;
        tick(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_ready = 1'b1;
        last_rx_cyc = cyc;
        tick(1);
        rx_ready = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        b = 8'($urandom_range(1, 254));
        if (b == 8'h55) b = 8'h56;
        return b;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done: done=%0b after %0d cycles, want 1", name, done, n);
        end
    endtask

    task automatic test_reset();
        activate = 1'b1; rx_ready = 1'b1; rx_data = 8'h33; reset = 1'b1;
        tick(4);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            tick(1);
            checks += 5;
            if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done[%0d]: got %0b want 0", s, done); end
            if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow[%0d]: got %0b want 0", s, overflow); end
            if (level !== 5'd0) begin errors++; $display("[TB] FAIL reset_level[%0d]: got %0d want 0", s, level); end
            if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start[%0d]: got %0b want 0", s, tx_start); end
            if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data[%0d]: got %02h want 00", s, tx_data); end
        end
        activate = 1'b0; rx_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] exp_q[$];
        int first_rx;
        exp_q = '{8'h10, 8'h20, 8'h55};
        start_test(0, 10);
        activate = 1'b1;
        tick(1);
        send_byte(8'h10); first_rx = last_rx_cyc; tick(1);
        send_byte(8'h20); tick(1);
        send_byte(8'h55);
        wait_done("stream", 200);
        checks++;
        if (got_q.size() != 3) begin errors++; $display("[TB] FAIL stream_count: got %0d starts want 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stream_seq[%0d]: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (start_cyc_q[0] != first_rx + 2) begin
            errors++; $display("[TB] FAIL stream_latency: tx_start cycle %0d want %0d", start_cyc_q[0], first_rx + 2);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (start_cyc_q[i] < start_cyc_q[i-1] + tx_time + 1) begin
                errors++; $display("[TB] FAIL stream_gap[%0d]: start at %0d, earliest allowed %0d", i, start_cyc_q[i], start_cyc_q[i-1] + tx_time + 1);
            end
        end
        checks += 2;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL stream_overflow: got %0b want 0", overflow); end
        if (overlap != 0) begin errors++; $display("[TB] FAIL stream_overlap: %0d starts while busy, want 0", overlap); end
        activate = 1'b0;
        tick(1);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL stream_release: done=%0b want 0", done); end
    endtask

    task automatic test_packet();
        logic [7:0] exp_q[$];
        start_test(1, 10);
        activate = 1'b1;
        tick(1);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            exp_q.push_back(8'(i));
            tick($urandom_range(0, 3));
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL packet_early: %0d starts before terminator, want 0", got_q.size()); end
        send_byte(8'h55);
        exp_q.push_back(8'h55);
        checks++;
        if (level !== 5'd6) begin errors++; $display("[TB] FAIL packet_level_full: got %0d want 6", level); end
        send_byte(8'h99);
        wait_done("packet", 300);
        checks++;
        if (got_q.size() != 6) begin errors++; $display("[TB] FAIL packet_count: got %0d starts want 6", got_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks += 2;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL packet_seq[%0d]: got %02h want %02h", i, got_q[i], exp_q[i]); end
            if (lvl_q[i] != 5 - i) begin errors++; $display("[TB] FAIL packet_level[%0d]: got %0d want %0d", i, lvl_q[i], 5 - i); end
        end
        checks += 2;
        if (level !== 5'd0) begin errors++; $display("[TB] FAIL packet_level_end: got %0d want 0", level); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL packet_overflow: got %0b want 0", overflow); end
        activate = 1'b0;
        tick(2);
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        bit ovf = 1'b0;
        start_test(2, 5);
        activate = 1'b1;
        tick(1);
        for (int k = 0; k < 7; k++) begin
            b = (k < 6) ? rand_byte() : 8'h55;
            send_byte(b);
            if (exp_q.size() < 4) exp_q.push_back(b);
            else ovf = 1'b1;
            checks += 2;
            if (int'(level) != exp_q.size()) begin errors++; $display("[TB] FAIL ovf_level[%0d]: got %0d want %0d", k, level, exp_q.size()); end
            if (overflow !== ovf) begin errors++; $display("[TB] FAIL ovf_flag[%0d]: got %0b want %0b", k, overflow, ovf); end
        end
        wait_done("ovf", 300);
        checks++;
        if (got_q.size() != 4) begin errors++; $display("[TB] FAIL ovf_count: got %0d starts want 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL ovf_seq[%0d]: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %0b want 1", overflow); end
        activate = 1'b0;
        tick(1);
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL ovf_release_done: got %0b want 0", done); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_release_clear: got %0b want 0", overflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        start_test(3, 6);
        activate = 1'b1;
        tick(1);
        for (int g = 0; g < 7; g++) begin
            for (int j = 0; j < ((g < 6) ? 3 : 2); j++) begin
                b = rand_byte();
                exp_q.push_back(b);
                send_byte(b);
            end
            tick(3 * (tx_time + 2) + 4);
        end
        send_byte(8'h55);
        exp_q.push_back(8'h55);
        wait_done("wrap", 300);
        checks++;
        if (got_q.size() != 21) begin errors++; $display("[TB] FAIL wrap_count: got %0d starts want 21", got_q.size()); end
        for (int i = 0; i < 21; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL wrap_seq[%0d]: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        checks += 3;
        if (max_level > 4) begin errors++; $display("[TB] FAIL wrap_max_level: got %0d want <=4", max_level); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL wrap_overflow: got %0b want 0", overflow); end
        if (overlap != 0) begin errors++; $display("[TB] FAIL wrap_overlap: %0d starts while busy, want 0", overlap); end
        activate = 1'b0;
        tick(2);
    endtask

    task automatic test_abort();
        logic [7:0] b[5];
        for (int i = 0; i < 5; i++) b[i] = rand_byte();
        start_test(0, 10);
        activate = 1'b1;
        tick(1);
        send_byte(b[0]);
        send_byte(b[1]);
        activate = 1'b0;
        tick(1);
        checks += 2;
        if (level !== 5'd0) begin errors++; $display("[TB] FAIL abort_level: got %0d want 0", level); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %0b want 0", done); end
        for (int i = 2; i < 5; i++) begin
            send_byte(b[i]);
            tick(2);
        end
        tick(30);
        checks += 4;
        if (got_q.size() != 1) begin errors++; $display("[TB] FAIL abort_starts: got %0d starts want 1", got_q.size()); end
        if (got_q[0] !== b[0]) begin errors++; $display("[TB] FAIL abort_first: got %02h want %02h", got_q[0], b[0]); end
        if (level !== 5'd0) begin errors++; $display("[TB] FAIL abort_level_late: got %0d want 0", level); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done_late: got %0b want 0", done); end
    endtask

    task automatic test_reset_mid_drain();
        int n = 0;
        start_test(1, 10);
        activate = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) send_byte(rand_byte());
        send_byte(8'h55);
        while (level !== 5'd3 && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (level !== 5'd3) begin errors++; $display("[TB] FAIL drain_reach_level: got %0d want 3", level); end
        reset = 1'b0;
        tick(1);
        checks += 5;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL drain_reset_done: got %0b want 0", done); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL drain_reset_overflow: got %0b want 0", overflow); end
        if (level !== 5'd0) begin errors++; $display("[TB] FAIL drain_reset_level: got %0d want 0", level); end
        if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL drain_reset_tx_start: got %0b want 0", tx_start); end
        if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL drain_reset_tx_data: got %02h want 00", tx_data); end
        reset = 1'b1;
        uart_reset();
        tick(1);
        send_byte(8'h7A);
        tick(1);
        send_byte(8'h55);
        wait_done("reactivate", 200);
        checks += 3;
        if (got_q.size() != 2) begin errors++; $display("[TB] FAIL reactivate_count: got %0d starts want 2", got_q.size()); end
        if (got_q[0] !== 8'h7A) begin errors++; $display("[TB] FAIL reactivate_seq[0]: got %02h want 7a", got_q[0]); end
        if (got_q[1] !== 8'h55) begin errors++; $display("[TB] FAIL reactivate_seq[1]: got %02h want 55", got_q[1]); end
        activate = 1'b0;
        tick(2);
    endtask

    initial begin
        tick(1);
        test_reset();
        test_stream();
        test_packet();
        test_overflow();
        test_wrap();
        test_abort();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
